// File: rtl/display_seq_pkg.sv
// Shared types and constants for the memory-game display sequencer.
//   seq_state_t : sequencer state encoding (IDLE, ARM, SHOW, GAP)
//   FRAME_CNT_W : width of every frame counter in the block
package display_seq_pkg;

    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: two-flop synchronizer on the active-low VGA vsync,
// followed by a falling-edge detect. tick is a registered one-cycle pulse that
// appears three clocks after the raw vsync falls.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset (synchronizer flops reset to 1 = vsync idle)
//   vga_vsync in  raw vsync, active low
//   tick      out one-cycle pulse per frame
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vga_vsync,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic tick_q, tick_d;

    always_comb begin
        sync1_d = vga_vsync;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = prev_q & ~sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/display_sequencer.sv
// Display sequencer for the memory-game VGA pattern. On start it waits for a
// frame boundary, shows the pattern for a level-dependent number of frames,
// blanks for a gap, then pulses input_phase. An independent timer keeps the
// answer indicator lit for a fixed number of frames.
// Optional build macro DISPLAY_SEQ_WARN_EN: blink the pattern during the last
// WARN_FRAMES frames of SHOW.
//
// State table:
//   IDLE | waiting for start
//   ARM  | start accepted, waiting for the first frame tick to align
//   SHOW | pattern visible, counting show frames
//   GAP  | pattern blank, counting gap frames before input phase
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              pulse: begin a sequence (ignored while busy)
//   o_level [1:0]      game level, sampled when start is accepted
//   vga_vsync          active-low vsync from vga_module
//   answer_valid       pulse: answer evaluated; answer_correct qualifies it
//   display            pattern visible
//   busy               sequence in progress (ARM/SHOW/GAP)
//   input_phase        pulse when the gap completes
//   flash_on, flash_ok answer indicator lit / latched correctness
module display_sequencer
    import display_seq_pkg::*;
#(
    parameter int SHOW_BASE    = 180,
    parameter int SHOW_STEP    = 40,
    parameter int GAP_FRAMES   = 30,
    parameter int FLASH_FRAMES = 45,
    parameter int BLINK_FRAMES = 8,
    parameter int WARN_FRAMES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] o_level,
    input  logic       vga_vsync,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic       display,
    output logic       busy,
    output logic       input_phase,
    output logic       flash_on,
    output logic       flash_ok
);

    localparam logic [FRAME_CNT_W-1:0] GAP_LEN   = FRAME_CNT_W'(GAP_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] FLASH_LEN = FRAME_CNT_W'(FLASH_FRAMES);

    // Level 3 must still leave a non-empty show window.
    if (!(SHOW_BASE > 3 * SHOW_STEP && SHOW_BASE <= 255 &&
          BLINK_FRAMES > 0 && WARN_FRAMES <= 255)) begin : g_bad_params
        $error("display_sequencer: illegal SHOW_BASE/SHOW_STEP/BLINK_FRAMES/WARN_FRAMES");
    end

    logic tick;

    frame_tick_gen u_frame_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .vga_vsync (vga_vsync),
        .tick      (tick)
    );

    seq_state_t             state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [FRAME_CNT_W-1:0] show_len_q, show_len_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   display_q, display_d;
    logic                   input_phase_q, input_phase_d;
    logic                   flash_on_q, flash_on_d;
    logic                   flash_ok_q, flash_ok_d;
`ifdef DISPLAY_SEQ_WARN_EN
    int                     warn_pos;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        show_len_d    = show_len_q;
        input_phase_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick coinciding with start is deliberately not used for alignment.
                if (start) begin
                    state_d    = ARM;
                    show_len_d = FRAME_CNT_W'(SHOW_BASE - int'(o_level) * SHOW_STEP);
                end
            end
            ARM: begin
                if (tick) begin
                    state_d = SHOW;
                    cnt_d   = show_len_q;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (cnt_q <= 8'd1) begin
                        if (GAP_FRAMES == 0) begin
                            state_d       = IDLE;
                            cnt_d         = '0;
                            input_phase_d = 1'b1;
                        end else begin
                            state_d = GAP;
                            cnt_d   = GAP_LEN;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_q <= 8'd1) begin
                        state_d       = IDLE;
                        cnt_d         = '0;
                        input_phase_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DISPLAY_SEQ_WARN_EN
        // Position inside the warning window; the blink starts low on entry
        // and flips every BLINK_FRAMES frames.
        warn_pos  = WARN_FRAMES - int'(cnt_d);
        display_d = (state_d == SHOW) &&
                    ((int'(cnt_d) > WARN_FRAMES) || ((warn_pos / BLINK_FRAMES) % 2 == 1));
`else
        display_d = (state_d == SHOW);
`endif

        // Flash timer runs regardless of the sequencer; a new answer always reloads.
        flash_on_d = flash_on_q;
        flash_ok_d = flash_ok_q;
        fcnt_d     = fcnt_q;
        if (answer_valid) begin
            flash_on_d = 1'b1;
            flash_ok_d = answer_correct;
            fcnt_d     = FLASH_LEN;
        end else if (flash_on_q && tick) begin
            if (fcnt_q <= 8'd1) begin
                flash_on_d = 1'b0;
                fcnt_d     = '0;
            end else begin
                fcnt_d = fcnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            show_len_q    <= '0;
            fcnt_q        <= '0;
            display_q     <= 1'b0;
            input_phase_q <= 1'b0;
            flash_on_q    <= 1'b0;
            flash_ok_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            show_len_q    <= show_len_d;
            fcnt_q        <= fcnt_d;
            display_q     <= display_d;
            input_phase_q <= input_phase_d;
            flash_on_q    <= flash_on_d;
            flash_ok_q    <= flash_ok_d;
        end
    end

    assign display     = display_q;
    assign busy        = (state_q != IDLE);
    assign input_phase = input_phase_q;
    assign flash_on    = flash_on_q;
    assign flash_ok    = flash_ok_q;

endmodule
